serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-bit unsigned subtractor computing diff = a - b with borrow-out.
- Processes DIGIT_W bits per clock, LSB digit first, with a registered borrow chain between digits.
- Trades latency for area by reusing one DIGIT_W-wide subtractor slice.
- Sits in the arithmetic micro-block set as the sequential, width-generalised successor of the 1-bit half/full subtractor cells.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 1.
- DIGIT_W, 1, bits processed per cycle; must divide WIDTH. Elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when the block is not busy
- a  input  WIDTH  minuend; latched on start acceptance
- b  input  WIDTH  subtrahend; latched on start acceptance
- busy  output  1  high while digits are being processed
- done  output  1  single-cycle pulse when the result becomes valid
- diff  output  WIDTH  result register; holds until the next completion
- borrow_out  output  1  final borrow (1 when a < b); held with diff
- zero  output  1  high when diff == 0; held with diff

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset state: FSM = IDLE. busy = 0, done = 0, diff = 0, borrow_out = 0, zero = 1. Internal operand regs, digit counter and borrow register = 0.
- D = WIDTH/DIGIT_W digits. Counter width is clog2(D), minimum 1.
- FSM states IDLE, RUN, DONE:
  - IDLE/DONE + start = 1 at edge k: latch a and b, clear the borrow register, clear the counter, go to RUN. start in DONE is accepted, so back-to-back operations are legal.
  - IDLE/DONE + start = 0: go to or remain in IDLE.
  - RUN at each edge: process digit[count]. The slice computes the digit of a minus the digit of b minus the registered borrow; it returns DIGIT_W result bits and a borrow. The result digit shifts into an internal result shift register (MSB side). The borrow register takes the slice borrow. count increments.
  - RUN at edge k+D (last digit): write diff, borrow_out and zero from the final shift value and borrow; go to DONE.
  - DONE lasts exactly one cycle, then IDLE unless start is accepted.
- busy = 1 exactly while in RUN (cycles k+1 .. k+D). done = 1 exactly while in DONE.
- Latency: done is asserted D cycles after the accepting edge. Throughput is one operation per D+1 cycles.
- start while in RUN is ignored. Operand changes after acceptance have no effect.
- diff, borrow_out and zero change only at the completion edge. They are stable between completions.
- Wrap-around: diff = (a - b) mod 2^WIDTH. For example a = 0, b = 1 gives diff = all-ones and borrow_out = 1.
- Reset asserted mid-RUN: immediate return to IDLE with reset values; the partial result is discarded; no done pulse.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_SAT_EN.
- Defined: saturating subtract. If the final borrow = 1, diff is forced to 0 and zero = 1; borrow_out is still 1 to flag underflow.
- Undefined: modular wrap-around result as specified above. No saturation logic is present.

Decomposition:
- Package serial_sub_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE), 2-bit encoding;
  - the function computing the counter width from D.
- One natural sub-module, sub_digit_slice: combinational DIGIT_W-wide ripple subtractor.
  - Inputs: a_d, b_d, bin. Outputs: d, bout.
  - Built from a full-subtractor cell per bit: d = x^y^bin, bout = (~x&y) | (~(x^y)&bin).
- The top module instantiates the slice once and holds the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, DIGIT_W=1: a=0x5A, b=0x23, start for 1 cycle -> busy for 8 cycles; done 8 cycles after accept; diff=0x37, borrow_out=0, zero=0.
- WIDTH=8, DIGIT_W=1: a=0x10, b=0x20 -> diff=0xF0, borrow_out=1. With SERIAL_SUBTRACTOR_SAT_EN: diff=0x00, borrow_out=1, zero=1.
- WIDTH=8, DIGIT_W=4: a=0xFF, b=0xFF -> done 2 cycles after accept; diff=0x00, borrow_out=0, zero=1. Then start held high in the DONE cycle with a=0x01, b=0x02 -> next result diff=0xFF, borrow_out=1, no idle gap.
- Pulse start again mid-RUN with different operands -> ignored; result matches the first operands; exactly one done pulse.
- Assert rst_n low at the 4th RUN cycle -> busy=0, done=0, diff=0, zero=1 asynchronously; no done pulse afterwards; the next operation completes correctly.
- Random a, b for 1000 operations at WIDTH=16 with DIGIT_W in {1, 2, 4, 16} -> diff and borrow_out match the reference model (a - b) mod 2^16 and (a < b).

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Digit counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned digits);
    return (digits <= 1) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/sub_digit_slice.sv
// Combinational DIGIT_W-wide ripple subtractor built from full-subtractor cells.
module sub_digit_slice #(
  parameter int unsigned DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a_d_i,
  input  logic [DIGIT_W-1:0] b_d_i,
  input  logic               bin_i,
  output logic [DIGIT_W-1:0] d_o,
  output logic               bout_o
);

  logic [DIGIT_W:0] br;

  assign br[0] = bin_i;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_bit
    assign d_o[i]    = a_d_i[i] ^ b_d_i[i] ^ br[i];
    assign br[i + 1] = (~a_d_i[i] & b_d_i[i]) | (~(a_d_i[i] ^ b_d_i[i]) & br[i]);
  end

  assign bout_o = br[DIGIT_W];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b, DIGIT_W bits per clock, LSB digit first.
// Define SERIAL_SUBTRACTOR_SAT_EN to clamp underflowing results to zero.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o,
  output logic             zero_o
);

  localparam int unsigned Digits = WIDTH / DIGIT_W;
  localparam int unsigned CntW   = cnt_width(Digits);

  if (WIDTH < 1 || DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_param_err
    $error("serial_subtractor: DIGIT_W must be >= 1 and divide WIDTH");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, res_q, diff_q;
  logic [CntW-1:0]   cnt_q;
  logic              borrow_q, bo_q, zero_q;

  logic [DIGIT_W-1:0] slice_d;
  logic               slice_bout;
  logic [WIDTH-1:0]   res_next, fin_diff;
  logic               fin_zero, last_digit, accept;

  sub_digit_slice #(
    .DIGIT_W(DIGIT_W)
  ) u_slice (
    .a_d_i (a_q[DIGIT_W-1:0]),
    .b_d_i (b_q[DIGIT_W-1:0]),
    .bin_i (borrow_q),
    .d_o   (slice_d),
    .bout_o(slice_bout)
  );

  // New digit enters at the MSB side; after Digits shifts the register holds the full result.
  assign res_next   = WIDTH'({slice_d, res_q} >> DIGIT_W);
  assign last_digit = (cnt_q == CntW'(Digits - 1));
  assign accept     = start_i && (state_q != StRun);

  always_comb begin
    fin_diff = res_next;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    if (slice_bout) begin
      fin_diff = '0;
    end
`endif
    fin_zero = (fin_diff == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = start_i ? StRun : StIdle;
      StRun:          state_d = last_digit ? StDone : StRun;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q == StRun);
    done_o = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bo_q     <= 1'b0;
      zero_q   <= 1'b1;
    end else if (accept) begin
      a_q      <= a_i;
      b_q      <= b_i;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
    end else if (state_q == StRun) begin
      a_q      <= a_q >> DIGIT_W;
      b_q      <= b_q >> DIGIT_W;
      res_q    <= res_next;
      borrow_q <= slice_bout;
      cnt_q    <= cnt_q + CntW'(1);
      if (last_digit) begin
        diff_q <= fin_diff;
        bo_q   <= slice_bout;
        zero_q <= fin_zero;
      end
    end
  end

  assign diff_o       = diff_q;
  assign borrow_out_o = bo_q;
  assign zero_o       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, back-to-back, reset and random ops.
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] diff;
    logic        bo;
    logic        z;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  logic clk, rst_n;
  logic start8a, start8b, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;

  logic        busy8a, done8a, bo8a, zero8a;
  logic        busy8b, done8b, bo8b, zero8b;
  logic [7:0]  diff8a, diff8b;
  logic        busy16 [4];
  logic        done16 [4];
  logic        bo16   [4];
  logic        zero16 [4];
  logic [15:0] diff16 [4];

  int   n_cmp, n_fail;
  int   dcnt8a, dcnt8b;
  exp_t q8a[$], q8b[$], q16[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT_W(1)) u_dut8a (
    .clk(clk), .rst_n(rst_n), .start_i(start8a), .a_i(a8), .b_i(b8),
    .busy_o(busy8a), .done_o(done8a), .diff_o(diff8a), .borrow_out_o(bo8a), .zero_o(zero8a)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT_W(4)) u_dut8b (
    .clk(clk), .rst_n(rst_n), .start_i(start8b), .a_i(a8), .b_i(b8),
    .busy_o(busy8b), .done_o(done8b), .diff_o(diff8b), .borrow_out_o(bo8b), .zero_o(zero8b)
  );

  for (genvar g = 0; g < 4; g++) begin : g_w16
    localparam int unsigned Dw = (g == 3) ? 16 : (1 << g);
    serial_subtractor #(.WIDTH(16), .DIGIT_W(Dw)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start_i(start16), .a_i(a16), .b_i(b16),
      .busy_o(busy16[g]), .done_o(done16[g]), .diff_o(diff16[g]),
      .borrow_out_o(bo16[g]), .zero_o(zero16[g])
    );
  end

  function automatic int unsigned dw_of(input int i);
    return (i == 3) ? 16 : (1 << i);
  endfunction

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] full;
    logic [15:0] mask;
    full   = {1'b0, a} - {1'b0, b};
    mask   = 16'((32'h1 << w) - 1);
    e.diff = full[15:0] & mask;
    e.bo   = (a < b);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    if (e.bo) e.diff = '0;
`endif
    e.z    = (e.diff == '0);
    return e;
  endfunction

  function automatic vec_t mkv(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] d, input logic bo, input logic z);
    vec_t v;
    v.a      = a;
    v.b      = b;
    v.e.diff = {8'h00, d};
    v.e.bo   = bo;
    v.e.z    = z;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock; outputs are sampled on the falling edge and 8-bit completions are scored here.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (done8a) begin
      dcnt8a++;
      if (q8a.size() == 0) chk("done8a_spurious", 32'(done8a), 32'd0);
      else begin
        e = q8a.pop_front();
        chk("diff8a", 32'(diff8a), 32'(e.diff[7:0]));
        chk("bo8a", 32'(bo8a), 32'(e.bo));
        chk("zero8a", 32'(zero8a), 32'(e.z));
      end
    end
    if (done8b) begin
      dcnt8b++;
      if (q8b.size() == 0) chk("done8b_spurious", 32'(done8b), 32'd0);
      else begin
        e = q8b.pop_front();
        chk("diff8b", 32'(diff8b), 32'(e.diff[7:0]));
        chk("bo8b", 32'(bo8b), 32'(e.bo));
        chk("zero8b", 32'(zero8b), 32'(e.z));
      end
    end
  endtask

  task automatic op8a(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    int lat, nb, d0;
    d0 = dcnt8a;
    a8 = a; b8 = b; start8a = 1'b1;
    q8a.push_back(e);
    step();
    start8a = 1'b0;
    lat = 1; nb = 0;
    while (dcnt8a == d0 && lat < 40) begin
      if (busy8a) nb++;
      step();
      lat++;
    end
    chk("lat8a", 32'(lat), 32'd9);
    chk("busy_cycles8a", 32'(nb), 32'd8);
  endtask

  vec_t vecs [5];

  initial begin
    int          d0, lat;
    logic [3:0]  seen;
    logic [15:0] gd [4];
    logic        gb [4];
    logic        gz [4];
    int          gl [4];
    exp_t        e;
    logic [7:0]  held;

    n_cmp = 0; n_fail = 0; dcnt8a = 0; dcnt8b = 0;
    rst_n = 1'b0; start8a = 1'b0; start8b = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;

    vecs[0] = mkv(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    vecs[1] = mkv(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
    vecs[2] = mkv(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    vecs[3] = mkv(8'h10, 8'h20, 8'h00, 1'b1, 1'b1);
    vecs[4] = mkv(8'h00, 8'h01, 8'h00, 1'b1, 1'b1);
`else
    vecs[3] = mkv(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    vecs[4] = mkv(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
`endif

    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_busy", 32'(busy8a), 32'd0);
    chk("rst_done", 32'(done8a), 32'd0);
    chk("rst_diff", 32'(diff8a), 32'd0);
    chk("rst_bo", 32'(bo8a), 32'd0);
    chk("rst_zero", 32'(zero8a), 32'd1);
    chk("rst_zero8b", 32'(zero8b), 32'd1);
    chk("rst_zero16", 32'(zero16[0]), 32'd1);

    for (int i = 0; i < 5; i++) op8a(vecs[i].a, vecs[i].b, vecs[i].e);

    // Back-to-back on the 4-bit-digit instance: start held through DONE.
    d0 = dcnt8b;
    a8 = 8'hFF; b8 = 8'hFF; start8b = 1'b1;
    q8b.push_back(model(8, 16'h00FF, 16'h00FF));
    step();
    a8 = 8'h01; b8 = 8'h02;
    q8b.push_back(model(8, 16'h0001, 16'h0002));
    step();
    chk("b2b_busy_run", 32'(busy8b), 32'd1);
    step();
    chk("b2b_done1", 32'(done8b), 32'd1);
    step();
    chk("b2b_no_gap", 32'(busy8b), 32'd1);
    start8b = 1'b0;
    lat = 0;
    while (dcnt8b < d0 + 2 && lat < 10) begin step(); lat++; end
    chk("b2b_done_count", 32'(dcnt8b - d0), 32'd2);
    chk("b2b_q_empty", 32'(q8b.size()), 32'd0);

    // Start during RUN must be ignored.
    d0 = dcnt8a;
    held = diff8a;
    a8 = 8'h5A; b8 = 8'h23; start8a = 1'b1;
    q8a.push_back(model(8, 16'h005A, 16'h0023));
    step();
    start8a = 1'b0;
    step(); step();
    a8 = 8'hFF; b8 = 8'h00; start8a = 1'b1;
    step();
    start8a = 1'b0;
    chk("diff_held_in_run", 32'(diff8a), 32'(held));
    lat = 0;
    while (dcnt8a == d0 && lat < 20) begin step(); lat++; end
    repeat (12) step();
    chk("midrun_done_count", 32'(dcnt8a - d0), 32'd1);

    // Make the held result nonzero with borrow, then reset in the 4th RUN cycle.
    op8a(8'h00, 8'h01, vecs[4].e);
    d0 = dcnt8a;
    a8 = 8'h5A; b8 = 8'h23; start8a = 1'b1;
    step();
    start8a = 1'b0;
    step(); step(); step();
    chk("pre_rst_busy", 32'(busy8a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy8a), 32'd0);
    chk("arst_done", 32'(done8a), 32'd0);
    chk("arst_diff", 32'(diff8a), 32'd0);
    chk("arst_bo", 32'(bo8a), 32'd0);
    chk("arst_zero", 32'(zero8a), 32'd1);
    step(); step();
    rst_n = 1'b1;
    repeat (12) step();
    chk("no_done_after_rst", 32'(dcnt8a - d0), 32'd0);
    op8a(8'h5A, 8'h23, model(8, 16'h005A, 16'h0023));

    // Random 16-bit ops on all four digit widths in parallel.
    for (int n = 0; n < 1000; n++) begin
      a16 = 16'($urandom_range(0, 65535));
      b16 = (n % 8 == 0) ? a16 : 16'($urandom_range(0, 65535));
      start16 = 1'b1;
      q16.push_back(model(16, a16, b16));
      step();
      start16 = 1'b0;
      for (int i = 0; i < 4; i++) chk("busy16_start", 32'(busy16[i]), 32'd1);
      lat = 1;
      seen = '0;
      while (seen != 4'hF && lat < 40) begin
        for (int i = 0; i < 4; i++) begin
          if (done16[i] && !seen[i]) begin
            seen[i] = 1'b1;
            gd[i] = diff16[i];
            gb[i] = bo16[i];
            gz[i] = zero16[i];
            gl[i] = lat;
          end
        end
        if (seen != 4'hF) begin step(); lat++; end
      end
      chk("done16_seen", 32'(seen), 32'hF);
      e = q16.pop_front();
      for (int i = 0; i < 4; i++) begin
        if (seen[i]) begin
          chk("diff16", 32'(gd[i]), 32'(e.diff));
          chk("bo16", 32'(gb[i]), 32'(e.bo));
          chk("zero16", 32'(gz[i]), 32'(e.z));
          chk("lat16", 32'(gl[i]), 32'(16 / dw_of(i) + 1));
        end
      end
    end

    repeat (3) step();
    chk("q8a_empty", 32'(q8a.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
